// File: rtl/voice_allocator_pkg.sv
// voice_allocator_pkg
// Shared types and helpers for the polyphonic voice allocator.
// Contents:
//   NUM_KEYS / DIV_W     keys per octave and divisor width
//   alloc_state_e        allocator FSM states
//   voice_t              per-voice table entry {valid, key, rank}
//   lowestSet()          priority encoder: lowest set bit of a key vector
//   divEntry()           extracts one divisor from the flat divider table
package voice_allocator_pkg;

    localparam int NUM_KEYS = 12;
    localparam int DIV_W    = 16;
    localparam int KEY_W    = 4;
    localparam int RANK_W   = 3;

    typedef logic [KEY_W-1:0]  keyIdx_t;
    typedef logic [RANK_W-1:0] rank_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_DIV,
        RELOAD
    } alloc_state_e;

    // Rank 0 is the most recently allocated voice; the oldest voice holds the
    // highest rank, which makes it the steal victim when every voice is busy.
    typedef struct packed {
        logic    valid;
        keyIdx_t key;
        rank_t   rank;
    } voice_t;

    function automatic keyIdx_t lowestSet(input logic [NUM_KEYS-1:0] vec);
        keyIdx_t idx;
        idx = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = keyIdx_t'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic [DIV_W-1:0] divEntry(input logic [NUM_KEYS*DIV_W-1:0] tbl,
                                                  input keyIdx_t k);
        return tbl[int'(k)*DIV_W +: DIV_W];
    endfunction

endpackage

// File: rtl/voice_allocator_if.sv
// voice_allocator_if
// Bundles the keypad/divider inputs and the voice control outputs of the
// voice allocator.
// Signals:
//   keys        debounced key levels, bit k = semitone k
//   octave      octave select (also drives the divider table generator)
//   div_table   flat divider table, entry k at [k*DIV_W +: DIV_W]
//   voice_en    voice v currently sounding
//   voice_div   registered divisor per voice
//   voice_load  one-cycle restart strobe per voice
//   steal       one-cycle strobe when an allocation evicts a held key
//   busy        allocator working or events pending
// Modports: master drives keys/octave/div_table, slave is the allocator.
interface voice_allocator_if #(
    parameter int NUM_VOICES = 4
);
    import voice_allocator_pkg::*;

    logic [NUM_KEYS-1:0]         keys;
    logic                        octave;
    logic [NUM_KEYS*DIV_W-1:0]   div_table;
    logic [NUM_VOICES-1:0]       voice_en;
    logic [NUM_VOICES*DIV_W-1:0] voice_div;
    logic [NUM_VOICES-1:0]       voice_load;
    logic                        steal;
    logic                        busy;

    modport master (
        output keys, octave, div_table,
        input  voice_en, voice_div, voice_load, steal, busy
    );

    modport slave (
        input  keys, octave, div_table,
        output voice_en, voice_div, voice_load, steal, busy
    );

endinterface

// File: rtl/voice_allocator_picker.sv
// voice_allocator_picker
// Combinational lookup over the voice table for one key.
// Ports:
//   voices_i      voice table
//   key_i         key being serviced
//   hit_o         some valid voice already holds key_i
//   hit_idx_o     lowest-index voice holding key_i
//   free_o        at least one voice is free
//   free_idx_o    lowest-index free voice
//   oldest_idx_o  valid voice with rank NUM_VOICES-1
module voice_allocator_picker
    import voice_allocator_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int VW         = $clog2(NUM_VOICES)
) (
    input  voice_t [NUM_VOICES-1:0] voices_i,
    input  keyIdx_t                 key_i,
    output logic                    hit_o,
    output logic [VW-1:0]           hit_idx_o,
    output logic                    free_o,
    output logic [VW-1:0]           free_idx_o,
    output logic [VW-1:0]           oldest_idx_o
);

    // Scanning from the top down lets the lowest index win each search.
    always_comb begin
        hit_o        = 1'b0;
        hit_idx_o    = '0;
        free_o       = 1'b0;
        free_idx_o   = '0;
        oldest_idx_o = '0;
        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            if (voices_i[v].valid && voices_i[v].key == key_i) begin
                hit_o     = 1'b1;
                hit_idx_o = VW'(v);
            end
            if (!voices_i[v].valid) begin
                free_o     = 1'b1;
                free_idx_o = VW'(v);
            end
            if (voices_i[v].valid && voices_i[v].rank == RANK_W'(NUM_VOICES - 1)) begin
                oldest_idx_o = VW'(v);
            end
        end
    end

endmodule

// File: rtl/voice_allocator.sv
// voice_allocator
// Polyphonic voice scheduler: maps held keys onto oscillator voices, loads
// each voice with its key's divisor, steals the oldest voice when all are busy
// and reloads every active voice after an octave change.
// Ports:
//   clk   system clock
//   rst   synchronous active-high reset
//   bus   voice_allocator_if.slave (keys, octave, div_table in;
//         voice_en, voice_div, voice_load, steal, busy out)
module voice_allocator
    import voice_allocator_pkg::*;
#(
    parameter int NUM_VOICES = 4
) (
    input  logic             clk,
    input  logic             rst,
    voice_allocator_if.slave bus
);

    localparam int VW = $clog2(NUM_VOICES);

    alloc_state_e                     state_q, state_d;
    logic [NUM_KEYS-1:0]              keys_q;
    logic [NUM_KEYS-1:0]              pendPress_q, pendPress_d;
    logic [NUM_KEYS-1:0]              pendRel_q, pendRel_d;
    logic                             octave_q;
    voice_t [NUM_VOICES-1:0]          voices_q;
    logic [NUM_VOICES-1:0][DIV_W-1:0] voiceDiv_q;
    logic [NUM_VOICES-1:0]            voiceLoad_q;
    logic                             steal_q;
    logic                             busy_q, busy_d;

    logic [NUM_KEYS-1:0] pressEdge, relEdge, svcMask;
    logic                octChange, svcRel, svcPress, anyRel, anyPress;
    keyIdx_t             svcKey;
    logic                hit, free;
    logic [VW-1:0]       hitIdx, freeIdx, oldestIdx, target;
    logic [RANK_W:0]     oldRank;

    voice_allocator_picker #(
        .NUM_VOICES (NUM_VOICES),
        .VW         (VW)
    ) u_picker (
        .voices_i     (voices_q),
        .key_i        (svcKey),
        .hit_o        (hit),
        .hit_idx_o    (hitIdx),
        .free_o       (free),
        .free_idx_o   (freeIdx),
        .oldest_idx_o (oldestIdx)
    );

    // Edge detection, event selection and pending bookkeeping. An octave
    // change seen in IDLE blocks servicing that cycle so the reload goes first;
    // releases always drain before presses.
    always_comb begin
        pressEdge = bus.keys & ~keys_q;
        relEdge   = ~bus.keys & keys_q;
        anyRel    = |pendRel_q;
        anyPress  = |pendPress_q;
        octChange = (state_q == IDLE) && (bus.octave != octave_q);
        svcRel    = (state_q == IDLE) && !octChange && anyRel;
        svcPress  = (state_q == IDLE) && !octChange && !anyRel && anyPress;
        svcKey    = anyRel ? lowestSet(pendRel_q) : lowestSet(pendPress_q);
        svcMask   = NUM_KEYS'(1) << svcKey;

        pendPress_d = ((pendPress_q & ~(svcPress ? svcMask : '0)) | pressEdge) & ~relEdge;
        pendRel_d   = ((pendRel_q & ~(svcRel ? svcMask : '0)) | relEdge) & ~pressEdge;

        state_d = state_q;
        unique case (state_q)
            IDLE:     if (octChange) state_d = WAIT_DIV;
            WAIT_DIV: state_d = RELOAD;
            RELOAD:   state_d = IDLE;
            default:  state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE) || (|pendPress_d) || (|pendRel_d);
    end

    // Press target: retrigger, else lowest free voice, else the oldest. A free
    // target's old rank counts as NUM_VOICES so every valid voice ages by one.
    always_comb begin
        target  = hit ? hitIdx : (free ? freeIdx : oldestIdx);
        oldRank = voices_q[target].valid ? {1'b0, voices_q[target].rank}
                                         : (RANK_W + 1)'(NUM_VOICES);
    end

    // FSM, voice table and registered outputs. Strobes default low and are
    // raised only in the cycle that services an event or performs the reload.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            keys_q      <= '0;
            pendPress_q <= '0;
            pendRel_q   <= '0;
            octave_q    <= 1'b0;
            voices_q    <= '0;
            voiceDiv_q  <= '0;
            voiceLoad_q <= '0;
            steal_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            keys_q      <= bus.keys;
            pendPress_q <= pendPress_d;
            pendRel_q   <= pendRel_d;
            busy_q      <= busy_d;
            voiceLoad_q <= '0;
            steal_q     <= 1'b0;

            if (octChange) begin
                octave_q <= bus.octave;
            end

            if (svcRel && hit) begin
                for (int v = 0; v < NUM_VOICES; v++) begin
                    if (voices_q[v].valid && voices_q[v].rank > voices_q[hitIdx].rank) begin
                        voices_q[v].rank <= voices_q[v].rank - rank_t'(1);
                    end
                end
                voices_q[hitIdx].valid <= 1'b0;
            end

            if (svcPress) begin
                for (int v = 0; v < NUM_VOICES; v++) begin
                    if (VW'(v) != target && voices_q[v].valid &&
                        {1'b0, voices_q[v].rank} < oldRank) begin
                        voices_q[v].rank <= voices_q[v].rank + rank_t'(1);
                    end
                end
                voices_q[target].valid <= 1'b1;
                voices_q[target].key   <= svcKey;
                voices_q[target].rank  <= '0;
                voiceDiv_q[target]     <= divEntry(bus.div_table, svcKey);
                voiceLoad_q[target]    <= 1'b1;
                steal_q                <= !hit && !free;
            end

            if (state_q == RELOAD) begin
                for (int v = 0; v < NUM_VOICES; v++) begin
                    if (voices_q[v].valid) begin
                        voiceDiv_q[v]  <= divEntry(bus.div_table, voices_q[v].key);
                        voiceLoad_q[v] <= 1'b1;
                    end
                end
            end
        end
    end

    // voice_en is the registered valid flag of each table entry.
    always_comb begin
        bus.voice_en = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            bus.voice_en[v] = voices_q[v].valid;
        end
    end

    assign bus.voice_div  = voiceDiv_q;
    assign bus.voice_load = voiceLoad_q;
    assign bus.steal      = steal_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_voice_allocator.sv
// tb_voice_allocator
// Directed bench for voice_allocator with four voices. The divider table is
// modelled as 1000+k (octave 0) and 500+k (octave 1).
module tb_voice_allocator;

    logic clk;
    logic rst;
    int   testsRun;
    int   testsFailed;

    voice_allocator_if #(.NUM_VOICES(4)) bus ();

    voice_allocator #(.NUM_VOICES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Divider table model driven from the current octave.
    always_comb begin
        bus.div_table = '0;
        for (int k = 0; k < 12; k++) begin
            bus.div_table[k*16 +: 16] = (bus.octave ? 16'd500 : 16'd1000) + 16'(k);
        end
    end

    function automatic logic [15:0] divOf(input int v);
        return bus.voice_div[v*16 +: 16];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        testsRun++; if (bus.voice_en !== 4'b0000) begin testsFailed++; $display("[TB] FAIL reset_en got %b expected %b", bus.voice_en, 4'b0000); end
        testsRun++; if (bus.voice_div !== 64'h0) begin testsFailed++; $display("[TB] FAIL reset_div got %h expected 0", bus.voice_div); end
        testsRun++; if (bus.voice_load !== 4'b0000) begin testsFailed++; $display("[TB] FAIL reset_load got %b expected 0000", bus.voice_load); end
        testsRun++; if (bus.steal !== 1'b0 || bus.busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_steal_busy got %b%b expected 00", bus.steal, bus.busy); end
        rst = 1'b0;
        tick();
        testsRun++; if (bus.busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL idle_busy got %b expected 0", bus.busy); end
    endtask

    task automatic test_single_press();
        bus.keys = 12'h008;
        tick();
        testsRun++; if (bus.busy !== 1'b1 || bus.voice_en !== 4'b0000) begin testsFailed++; $display("[TB] FAIL press_pending got busy=%b en=%b expected busy=1 en=0000", bus.busy, bus.voice_en); end
        tick();
        testsRun++; if (bus.voice_en !== 4'b0001) begin testsFailed++; $display("[TB] FAIL press_en got %b expected 0001", bus.voice_en); end
        testsRun++; if (divOf(0) !== 16'd1003) begin testsFailed++; $display("[TB] FAIL press_div got %0d expected 1003", divOf(0)); end
        testsRun++; if (bus.voice_load !== 4'b0001 || bus.busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL press_load got load=%b busy=%b expected 0001/0", bus.voice_load, bus.busy); end
        tick();
        testsRun++; if (bus.voice_load !== 4'b0000 || bus.voice_en !== 4'b0001) begin testsFailed++; $display("[TB] FAIL press_pulse got load=%b en=%b expected 0000/0001", bus.voice_load, bus.voice_en); end
    endtask

    task automatic test_steal();
        bus.keys = 12'h2AA;
        tick();
        testsRun++; if (bus.busy !== 1'b1) begin testsFailed++; $display("[TB] FAIL steal_busy got %b expected 1", bus.busy); end
        tick();
        testsRun++; if (bus.voice_load !== 4'b0010 || divOf(1) !== 16'd1001) begin testsFailed++; $display("[TB] FAIL alloc_k1 got load=%b div=%0d expected 0010/1001", bus.voice_load, divOf(1)); end
        tick();
        testsRun++; if (bus.voice_load !== 4'b0100 || divOf(2) !== 16'd1005) begin testsFailed++; $display("[TB] FAIL alloc_k5 got load=%b div=%0d expected 0100/1005", bus.voice_load, divOf(2)); end
        tick();
        testsRun++; if (bus.voice_load !== 4'b1000 || divOf(3) !== 16'd1007) begin testsFailed++; $display("[TB] FAIL alloc_k7 got load=%b div=%0d expected 1000/1007", bus.voice_load, divOf(3)); end
        tick();
        testsRun++; if (bus.voice_load !== 4'b0001 || divOf(0) !== 16'd1009) begin testsFailed++; $display("[TB] FAIL steal_k9 got load=%b div=%0d expected 0001/1009", bus.voice_load, divOf(0)); end
        testsRun++; if (bus.steal !== 1'b1 || bus.voice_en !== 4'b1111) begin testsFailed++; $display("[TB] FAIL steal_pulse got steal=%b en=%b expected 1/1111", bus.steal, bus.voice_en); end
        tick();
        testsRun++; if (bus.steal !== 1'b0 || bus.busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL steal_done got steal=%b busy=%b expected 0/0", bus.steal, bus.busy); end
        bus.keys = 12'h2A2;
        tick();
        tick();
        testsRun++; if (bus.voice_en !== 4'b1111 || bus.voice_load !== 4'b0000 || bus.busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL stolen_release got en=%b load=%b busy=%b expected 1111/0000/0", bus.voice_en, bus.voice_load, bus.busy); end
        bus.keys = 12'h2A0;
        tick();
        tick();
        testsRun++; if (bus.voice_en !== 4'b1101) begin testsFailed++; $display("[TB] FAIL release_k1 got %b expected 1101", bus.voice_en); end
        bus.keys = 12'h000;
        for (int i = 0; i < 4; i++) tick();
        testsRun++; if (bus.voice_en !== 4'b0000 || bus.busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL release_all got en=%b busy=%b expected 0000/0", bus.voice_en, bus.busy); end
    endtask

    task automatic test_octave_reload();
        bus.keys = 12'h014;
        tick();
        tick();
        tick();
        testsRun++; if (bus.voice_en !== 4'b0011 || divOf(0) !== 16'd1002 || divOf(1) !== 16'd1004) begin testsFailed++; $display("[TB] FAIL oct_setup got en=%b div0=%0d div1=%0d expected 0011/1002/1004", bus.voice_en, divOf(0), divOf(1)); end
        bus.octave = 1'b1;
        tick();
        testsRun++; if (bus.busy !== 1'b1 || bus.voice_load !== 4'b0000) begin testsFailed++; $display("[TB] FAIL oct_wait got busy=%b load=%b expected 1/0000", bus.busy, bus.voice_load); end
        bus.keys = 12'h114;
        tick();
        testsRun++; if (bus.voice_load !== 4'b0000) begin testsFailed++; $display("[TB] FAIL oct_early_load got %b expected 0000", bus.voice_load); end
        tick();
        testsRun++; if (bus.voice_load !== 4'b0011 || divOf(0) !== 16'd502 || divOf(1) !== 16'd504) begin testsFailed++; $display("[TB] FAIL oct_reload got load=%b div0=%0d div1=%0d expected 0011/502/504", bus.voice_load, divOf(0), divOf(1)); end
        tick();
        testsRun++; if (bus.voice_load !== 4'b0100 || divOf(2) !== 16'd508 || bus.voice_en !== 4'b0111) begin testsFailed++; $display("[TB] FAIL oct_deferred_press got load=%b div2=%0d en=%b expected 0100/508/0111", bus.voice_load, divOf(2), bus.voice_en); end
        bus.keys = 12'hD14;
        tick();
        tick();
        testsRun++; if (bus.voice_load !== 4'b1000 || divOf(3) !== 16'd510 || bus.steal !== 1'b0) begin testsFailed++; $display("[TB] FAIL oct_k10 got load=%b div3=%0d steal=%b expected 1000/510/0", bus.voice_load, divOf(3), bus.steal); end
        tick();
        testsRun++; if (bus.voice_load !== 4'b0001 || divOf(0) !== 16'd511 || bus.steal !== 1'b1) begin testsFailed++; $display("[TB] FAIL oct_rank_steal got load=%b div0=%0d steal=%b expected 0001/511/1", bus.voice_load, divOf(0), bus.steal); end
        bus.keys   = 12'h000;
        bus.octave = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        testsRun++; if (bus.voice_en !== 4'b0000 || bus.busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL oct_cleanup got en=%b busy=%b expected 0000/0", bus.voice_en, bus.busy); end
    endtask

    task automatic test_press_release_race();
        bus.octave = 1'b1;
        bus.keys   = 12'h040;
        tick();
        testsRun++; if (bus.busy !== 1'b1) begin testsFailed++; $display("[TB] FAIL race_busy got %b expected 1", bus.busy); end
        bus.keys = 12'h000;
        for (int i = 0; i < 3; i++) begin
            tick();
            testsRun++; if (bus.voice_en !== 4'b0000 || bus.voice_load !== 4'b0000) begin testsFailed++; $display("[TB] FAIL race_no_alloc got en=%b load=%b expected 0000/0000", bus.voice_en, bus.voice_load); end
        end
        testsRun++; if (bus.busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL race_idle got busy=%b expected 0", bus.busy); end
        bus.octave = 1'b0;
        for (int i = 0; i < 4; i++) tick();
    endtask

    task automatic test_reset_held_key();
        bus.keys = 12'h001;
        rst      = 1'b1;
        tick();
        tick();
        testsRun++; if (bus.voice_en !== 4'b0000 || bus.busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL held_in_reset got en=%b busy=%b expected 0000/0", bus.voice_en, bus.busy); end
        rst = 1'b0;
        tick();
        tick();
        testsRun++; if (bus.voice_en !== 4'b0001 || divOf(0) !== 16'd1000 || bus.voice_load !== 4'b0001) begin testsFailed++; $display("[TB] FAIL held_alloc got en=%b div0=%0d load=%b expected 0001/1000/0001", bus.voice_en, divOf(0), bus.voice_load); end
        bus.keys = 12'h00F;
        tick();
        testsRun++; if (bus.busy !== 1'b1) begin testsFailed++; $display("[TB] FAIL pend3_busy got %b expected 1", bus.busy); end
        rst = 1'b1;
        tick();
        testsRun++; if (bus.voice_en !== 4'b0000 || bus.voice_div !== 64'h0 || bus.voice_load !== 4'b0000 || bus.busy !== 1'b0 || bus.steal !== 1'b0) begin testsFailed++; $display("[TB] FAIL midrun_reset got en=%b div=%h load=%b busy=%b expected all zero", bus.voice_en, bus.voice_div, bus.voice_load, bus.busy); end
        bus.keys = 12'h000;
        rst      = 1'b0;
        tick();
        tick();
        testsRun++; if (bus.voice_en !== 4'b0000 || bus.busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL post_reset got en=%b busy=%b expected 0000/0", bus.voice_en, bus.busy); end
    endtask

    task automatic test_retrigger();
        bus.keys = 12'h001;
        tick();
        tick();
        bus.keys = 12'h021;
        tick();
        tick();
        testsRun++; if (bus.voice_en !== 4'b0011 || divOf(1) !== 16'd1005) begin testsFailed++; $display("[TB] FAIL retrig_setup got en=%b div1=%0d expected 0011/1005", bus.voice_en, divOf(1)); end
        bus.octave = 1'b1;
        bus.keys   = 12'h001;
        tick();
        bus.keys = 12'h021;
        tick();
        tick();
        testsRun++; if (bus.voice_load !== 4'b0011 || divOf(0) !== 16'd500 || divOf(1) !== 16'd505) begin testsFailed++; $display("[TB] FAIL retrig_reload got load=%b div0=%0d div1=%0d expected 0011/500/505", bus.voice_load, divOf(0), divOf(1)); end
        tick();
        testsRun++; if (bus.voice_load !== 4'b0010 || divOf(1) !== 16'd505) begin testsFailed++; $display("[TB] FAIL retrig_same_voice got load=%b div1=%0d expected 0010/505", bus.voice_load, divOf(1)); end
        testsRun++; if (bus.voice_en !== 4'b0011 || bus.steal !== 1'b0) begin testsFailed++; $display("[TB] FAIL retrig_free_stay got en=%b steal=%b expected 0011/0", bus.voice_en, bus.steal); end
        tick();
        testsRun++; if (bus.voice_load !== 4'b0000 || bus.busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL retrig_done got load=%b busy=%b expected 0000/0", bus.voice_load, bus.busy); end
    endtask

    // Directed scenarios run back to back from a single reset.
    initial begin
        testsRun    = 0;
        testsFailed = 0;
        rst         = 1'b1;
        bus.keys    = 12'h000;
        bus.octave  = 1'b0;
        tick();
        tick();
        test_reset();
        test_single_press();
        test_steal();
        test_octave_reload();
        test_press_release_race();
        test_reset_held_key();
        test_retrigger();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
